// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control FSM and the memory.
// The controller is the master: it raises read/write requests and selects the
// address source; the memory answers with mem_ready on the cycle it completes.
interface multicycle_ctrl_if;
    logic mem_rd;
    logic mem_wr;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_rd,
        output mem_wr,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV64 core: sequences fetch, decode,
// execute, memory and writeback over the shared ALU, memory port and register
// file. Memory accesses are guarded by a watchdog; a timeout or an unsupported
// opcode parks the core in TRAP until reset.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                alu_zero,
    multicycle_ctrl_if.master   mem,
    output logic [2:0]          imm_type,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_op,
    output logic                pc_src,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                halted
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Last wait-counter value before the watchdog fires: a state that has
    // already waited MEM_TIMEOUT-1 cycles and still sees no mem_ready traps.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        RST     = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EX_R    = 4'd3,
        EX_I    = 4'd4,
        WB_ALU  = 4'd5,
        ADDR    = 4'd6,
        LD_MEM  = 4'd7,
        LD_WB   = 4'd8,
        ST_MEM  = 4'd9,
        BRANCH  = 4'd10,
        JAL     = 4'd11,
        JALR    = 4'd12,
        JALR_WB = 4'd13,
        LUI     = 4'd14,
        TRAP    = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       imm_dec;
    logic             branch_taken;
    logic             cnt_at_limit;

    assign cnt_at_limit = (cnt_q == CNT_LIMIT);

    // Immediate format implied by the current opcode (I is the fallback).
    always_comb begin
        imm_dec = 3'b000;
        case (opcode)
            OP_ST:   imm_dec = 3'b001;
            OP_BR:   imm_dec = 3'b010;
            OP_JAL:  imm_dec = 3'b011;
            OP_LUI:  imm_dec = 3'b100;
            default: imm_dec = 3'b000;
        endcase
    end

    // BEQ/BNE resolution; every other funct3 falls through untaken.
    always_comb begin
        branch_taken = 1'b0;
        if (funct3 == 3'b000) begin
            branch_taken = alu_zero;
        end else if (funct3 == 3'b001) begin
            branch_taken = ~alu_zero;
        end
    end

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and watchdog counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST:    state_d = FETCH;
            FETCH, LD_MEM, ST_MEM: begin
                if (mem.mem_ready) begin
                    case (state_q)
                        FETCH:   state_d = DECODE;
                        LD_MEM:  state_d = LD_WB;
                        default: state_d = FETCH;
                    endcase
                end else if (cnt_at_limit) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:          state_d = EX_R;
                    OP_I:          state_d = EX_I;
                    OP_LD, OP_ST:  state_d = ADDR;
                    OP_BR:         state_d = BRANCH;
                    OP_JAL:        state_d = JAL;
                    OP_JALR:       state_d = JALR;
                    OP_LUI:        state_d = LUI;
                    default:       state_d = TRAP;
                endcase
            end
            EX_R, EX_I: state_d = WB_ALU;
            WB_ALU:     state_d = FETCH;
            ADDR:       state_d = opcode[5] ? ST_MEM : LD_MEM;
            LD_WB:      state_d = FETCH;
            BRANCH:     state_d = FETCH;
            JAL:        state_d = FETCH;
            JALR:       state_d = JALR_WB;
            JALR_WB:    state_d = FETCH;
            LUI:        state_d = FETCH;
            TRAP:       state_d = TRAP;
            default:    state_d = RST;
        endcase
        // Every fresh entry into a memory-waiting state restarts the watchdog.
        if ((state_d != state_q) &&
            ((state_d == FETCH) || (state_d == LD_MEM) || (state_d == ST_MEM))) begin
            cnt_d = '0;
        end
    end

    // Moore control outputs; the only input-qualified strobes are the fetch
    // completion writes and the branch-taken PC load.
    always_comb begin
        imm_type    = 3'b000;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 3'd0;
        pc_src      = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem.mem_rd  = 1'b0;
        mem.mem_wr  = 1'b0;
        mem.iord    = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 2'd0;
        halted      = 1'b0;
        case (state_q)
            FETCH: begin
                mem.mem_rd = 1'b1;
                alu_src_b  = 2'd1;
                ir_write   = mem.mem_ready;
                pc_write   = mem.mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'd2;
            end
            EX_R: begin
                alu_src_a = 2'd1;
                alu_op    = 3'd2;
            end
            EX_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 3'd2;
            end
            WB_ALU: begin
                reg_write = 1'b1;
            end
            ADDR, JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            LD_MEM: begin
                mem.mem_rd = 1'b1;
                mem.iord   = 1'b1;
            end
            LD_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
            end
            ST_MEM: begin
                mem.mem_wr = 1'b1;
                mem.iord   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 3'd1;
                pc_write  = branch_taken;
                pc_src    = branch_taken;
            end
            JAL, JALR_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
            end
            LUI: begin
                reg_write = 1'b1;
                wb_sel    = 2'd3;
            end
            TRAP: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
        // The immediate format stays on the sign-extender from DECODE until the
        // instruction retires.
        if ((state_q != RST) && (state_q != FETCH) && (state_q != TRAP)) begin
            imm_type = imm_dec;
        end
    end

endmodule
